// File: rtl/jt1943_arb_pkg.sv
// Shared types and defaults for the 1943 SDRAM read arbiter.
package jt1943_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  localparam int SLOTS_DEF = 4;
  localparam int AW_DEF    = 22;
  localparam int DW        = 32;

  // Index width that stays legal for a single-slot build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jt1943_arb_rr.sv
// Round-robin picker: first asserted miss at or after ptr, wrapping around.
module jt1943_arb_rr
  import jt1943_arb_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int PW    = idx_w(SLOTS)
)(
  input  logic [SLOTS-1:0] miss,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    grant,
  output logic             any_req
);

  int idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    grant   = ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (miss[idx]) begin
        grant   = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jt1943_sdram_arb.sv
// Time-shares the SDRAM read port between ROM requesters, each backed by a
// one-word tagged cache; one read is in flight at a time.
module jt1943_sdram_arb
  import jt1943_arb_pkg::*;
#(
  parameter int SLOTS  = SLOTS_DEF,
  parameter int AW     = AW_DEF,
  parameter int TO_MAX = 255
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic [SLOTS-1:0]    slot_ok,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                timeout
);

  localparam int            PW      = idx_w(SLOTS);
  localparam int            CW      = $clog2(TO_MAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_MAX - 1);

  arb_state_t       state;
  logic [PW-1:0]    cur;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant;
  logic             any_req;
  logic [CW-1:0]    wd_cnt;
  logic             wd_expired;
  logic [SLOTS-1:0] valid;
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] miss;
  logic [AW-1:0]    tag    [SLOTS];
  logic [DW-1:0]    data   [SLOTS];
  logic [AW-1:0]    addr_a [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr_a[i]              = slot_addr[i*AW +: AW];
    assign slot_dout[i*DW +: DW]  = data[i];
  end

  // The slot being fetched is not a miss: it must not be requested twice.
  always_comb begin
    hit  = '0;
    miss = '0;
    for (int i = 0; i < SLOTS; i++) begin
      hit[i]  = slot_cs[i] & valid[i] & (tag[i] == addr_a[i]);
      miss[i] = slot_cs[i] & ~hit[i] & ~((state != ST_IDLE) && (cur == PW'(i)));
    end
  end

  jt1943_arb_rr #(
    .SLOTS (SLOTS),
    .PW    (PW)
  ) u_rr (
    .miss    (miss),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign wd_expired = (wd_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      timeout    <= 1'b0;
      slot_ok    <= '0;
      valid      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      timeout <= 1'b0;
      slot_ok <= hit & ~{SLOTS{downloading}};
      if (downloading) begin
        // A ROM load invalidates everything and abandons any pending read.
        state     <= ST_IDLE;
        sdram_req <= 1'b0;
        valid     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (any_req) begin
              cur        <= grant;
              sdram_addr <= addr_a[grant];
              sdram_req  <= 1'b1;
              wd_cnt     <= '0;
              rr_ptr     <= (grant == PW'(SLOTS - 1)) ? '0 : grant + 1'b1;
              state      <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (sdram_ack) begin
              sdram_req <= 1'b0;
              wd_cnt    <= '0;
              state     <= ST_WAIT;
            end else if (wd_expired) begin
              sdram_req <= 1'b0;
              timeout   <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (data_rdy) begin
              data[cur]  <= data_read;
              tag[cur]   <= sdram_addr;
              valid[cur] <= 1'b1;
              state      <= ST_IDLE;
            end else if (wd_expired) begin
              timeout <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt1943_sdram_arb.sv
// Bench for jt1943_sdram_arb: directed scenarios plus a randomized phase,
// checked against a per-slot cache model and a round-robin grant model.
module tb_jt1943_sdram_arb;

  localparam int SLOTS  = 4;
  localparam int AW     = 22;
  localparam int TO_MAX = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         downloading = 1'b0;
  logic [3:0]   slot_cs = '0;
  logic [87:0]  slot_addr = '0;
  logic [127:0] slot_dout;
  logic [3:0]   slot_ok;
  logic         sdram_req;
  logic [21:0]  sdram_addr;
  logic         sdram_ack = 1'b0;
  logic         data_rdy = 1'b0;
  logic [31:0]  data_read = '0;
  logic         timeout;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [21:0] m_tag  [4];
  logic [31:0] m_data [4];
  logic [3:0]  m_valid;
  int          m_rr;
  int          m_cur;
  logic [21:0] m_addr;
  bit          m_wait;
  bit          exp_to;

  jt1943_sdram_arb #(
    .SLOTS  (SLOTS),
    .AW     (AW),
    .TO_MAX (TO_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_dout   (slot_dout),
    .slot_ok     (slot_ok),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] addr_of(input int i);
    return slot_addr[i*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [21:0] a);
    slot_addr[i*AW +: AW] = a;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
    m_valid = '0;
    m_rr    = 0;
    m_cur   = 0;
    m_addr  = '0;
    m_wait  = 1'b0;
    exp_to  = 1'b0;
  endtask

  function automatic logic [3:0] model_hit();
    logic [3:0] h;
    h = '0;
    for (int i = 0; i < 4; i++)
      h[i] = slot_cs[i] && m_valid[i] && (m_tag[i] == addr_of(i));
    return h;
  endfunction

  // Next slot to be served while idle, or -1 when nothing misses.
  function automatic int model_pick();
    logic [3:0] h;
    int s;
    h = model_hit();
    for (int k = 0; k < 4; k++) begin
      s = (m_rr + k) % 4;
      if (slot_cs[s] && !h[s]) return s;
    end
    return -1;
  endfunction

  // One clock: advance the model across the edge and check the per-cycle outputs.
  task automatic step();
    logic [3:0]   h;
    logic [127:0] exp_dout;
    bit           dl;
    h  = model_hit();
    dl = downloading;
    @(posedge clk);
    #1;
    if (dl) begin
      m_valid = '0;
      m_wait  = 1'b0;
    end else if (data_rdy && m_wait) begin
      m_tag[m_cur]   = m_addr;
      m_data[m_cur]  = data_read;
      m_valid[m_cur] = 1'b1;
      m_wait         = 1'b0;
    end
    for (int i = 0; i < 4; i++) exp_dout[i*32 +: 32] = m_data[i];
    chk("slot_ok", slot_ok, dl ? 4'b0000 : h);
    chk("slot_dout", slot_dout, exp_dout);
    chk("timeout", timeout, exp_to);
  endtask

  task automatic grant_step(output int g);
    g = model_pick();
    step();
    chk("req_rise", sdram_req, 1'b1);
    chk("grant_exists", (g >= 0), 1'b1);
    if (g >= 0) begin
      chk("req_addr", sdram_addr, addr_of(g));
      m_cur  = g;
      m_addr = addr_of(g);
      m_rr   = (g + 1) % 4;
    end
  endtask

  task automatic fetch(input int ack_dly, input int rdy_dly, input logic [31:0] dat,
                       input int chg_slot, input logic [21:0] chg_addr,
                       input bit rdy_in_req, output int g);
    grant_step(g);
    for (int k = 0; k < ack_dly; k++) begin
      data_rdy  = rdy_in_req && (k == 0);
      data_read = $urandom;
      step();
      data_rdy = 1'b0;
      chk("req_hold", sdram_req, 1'b1);
      chk("addr_hold", sdram_addr, m_addr);
    end
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk("req_drop", sdram_req, 1'b0);
    m_wait = 1'b1;
    if (chg_slot >= 0) set_addr(chg_slot, chg_addr);
    for (int k = 0; k < rdy_dly; k++) begin
      step();
      chk("req_wait", sdram_req, 1'b0);
    end
    data_read = dat;
    data_rdy  = 1'b1;
    step();
    data_rdy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int g;
    int order [4];
    int chg;
    order = '{2, 3, 0, 1};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slot_ok", slot_ok, 4'b0000);
    chk("rst_slot_dout", slot_dout, '0);
    chk("rst_sdram_req", sdram_req, 1'b0);
    chk("rst_sdram_addr", sdram_addr, '0);
    chk("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;

    // Single miss on slot 1, with a stray data_rdy while still in REQ
    slot_cs = 4'b0010;
    set_addr(1, 22'h00123);
    fetch(2, 2, 32'hDEADBEEF, -1, '0, 1'b1, g);
    chk("single_grant", g, 1);
    step();
    chk("single_ok", slot_ok[1], 1'b1);
    chk("single_dout", slot_dout[63:32], 32'hDEADBEEF);

    // Hit hold: no traffic, slot_ok steady
    repeat (50) begin
      step();
      chk("hold_req", sdram_req, 1'b0);
      chk("hold_ok", slot_ok[1], 1'b1);
    end

    // Fairness: all four miss with the pointer at 2
    slot_cs = 4'hF;
    set_addr(0, 22'h00200);
    set_addr(1, 22'h00124);
    set_addr(2, 22'h00202);
    set_addr(3, 22'h00203);
    for (int j = 0; j < 4; j++) begin
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, -1, '0, 1'b0, g);
      chk("fair_order", g, order[j]);
    end
    step();
    chk("fair_all_ok", slot_ok, 4'hF);

    // Address change while the fetch is in WAIT
    set_addr(0, 22'h00010);
    fetch(1, 2, $urandom, 0, 22'h00011, 1'b0, g);
    chk("mid_grant", g, 0);
    fetch(0, 1, 32'h0000_1111, -1, '0, 1'b0, g);
    chk("mid_regrant", g, 0);
    step();
    chk("mid_new_ok", slot_ok[0], 1'b1);

    // Watchdog: acknowledged but data never returns
    set_addr(2, 22'h03333);
    grant_step(g);
    chk("wd_grant", g, 2);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk("wd_req_drop", sdram_req, 1'b0);
    m_wait = 1'b1;
    for (int k = 1; k <= TO_MAX; k++) begin
      exp_to = (k == TO_MAX);
      step();
    end
    exp_to = 1'b0;
    m_wait = 1'b0;
    chk("wd_req_idle", sdram_req, 1'b0);
    fetch(0, 0, $urandom, -1, '0, 1'b0, g);
    chk("wd_retry", g, 2);

    // Download abort during REQ
    set_addr(3, 22'h04444);
    grant_step(g);
    chk("dl_grant", g, 3);
    downloading = 1'b1;
    step();
    chk("dl_req_drop", sdram_req, 1'b0);
    chk("dl_ok", slot_ok, 4'b0000);
    repeat (6) begin
      step();
      chk("dl_no_req", sdram_req, 1'b0);
    end
    downloading = 1'b0;
    for (int n = 0; n < 8 && model_pick() >= 0; n++)
      fetch($urandom_range(0, 2), $urandom_range(0, 2), $urandom, -1, '0, 1'b0, g);
    step();
    chk("dl_refill_ok", slot_ok, 4'hF);

    // Randomized traffic over a small address pool
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) slot_cs[i] = ~slot_cs[i];
        if ($urandom_range(0, 2) == 0)
          set_addr(i, 22'(32'h1000 * (i + 1) + $urandom_range(0, 2)));
      end
      if (model_pick() >= 0) begin
        chg = $urandom_range(0, 5);
        fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
              (chg > 3) ? -1 : chg, 22'(32'h1000 * (chg + 1) + $urandom_range(0, 2)),
              1'b0, g);
      end else begin
        step();
        chk("rand_idle_req", sdram_req, 1'b0);
      end
    end

    // Asynchronous reset in the middle of a request
    slot_cs = 4'hF;
    set_addr(1, 22'h05555);
    grant_step(g);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", sdram_req, 1'b0);
    chk("arst_addr", sdram_addr, '0);
    chk("arst_ok", slot_ok, 4'b0000);
    chk("arst_dout", slot_dout, '0);
    chk("arst_timeout", timeout, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
